// File: rtl/sevenseg_capture.sv
// Snoops an active-low multiplexed 7-seg bus and recovers the shown hex word.
// Define SEVENSEG_CAPTURE_SYNC_EN to add a 2-flop input synchronizer.
module sevenseg_capture #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   an_n,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   digit_valid,
  output logic              cap_stb,
  output logic              err_stb,
  output logic              frame_stb
);

  localparam logic [7:0] CMAX = 8'(STABLE_CYC - 1);

  logic [6:0]      seg_s;
  logic [6:0]      seg_h;
  logic [NDIG-1:0] an_s;
  logic [NDIG-1:0] an_h;
  logic [7:0]      cnt;
  logic [7:0]      cnt_nxt;
  logic            armed;
  logic [NDIG-1:0] seen;
  logic [NDIG-1:0] seen_or;
  logic [3:0]      ones;
  logic [3:0]      nib;
  logic            same;
  logic            legal;
  logic            fire;
  logic            hit;
  logic            blank;
  logic            all_seen;

`ifdef SEVENSEG_CAPTURE_SYNC_EN
  logic [6:0]      seg_m;
  logic [NDIG-1:0] an_m;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_m <= '0;
      an_m  <= '0;
      seg_s <= '0;
      an_s  <= '0;
    end else begin
      seg_m <= ~seg_n;
      an_m  <= ~an_n;
      seg_s <= seg_m;
      an_s  <= an_m;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s <= '0;
      an_s  <= '0;
    end else begin
      seg_s <= ~seg_n;
      an_s  <= ~an_n;
    end
  end
`endif

  // Active-high gfedcba back to {hit, nibble}
  function automatic logic [4:0] dec7(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3f:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5b:   r = {1'b1, 4'h2};
      7'h4f:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6d:   r = {1'b1, 4'h5};
      7'h7d:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7f:   r = {1'b1, 4'h8};
      7'h6f:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'ha};
      7'h7c:   r = {1'b1, 4'hb};
      7'h39:   r = {1'b1, 4'hc};
      7'h5e:   r = {1'b1, 4'hd};
      7'h79:   r = {1'b1, 4'he};
      7'h71:   r = {1'b1, 4'hf};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    same = (seg_s == seg_h) && (an_s == an_h);
    if (!same)
      cnt_nxt = '0;
    else if (cnt == CMAX)
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + 8'd1;

    ones = '0;
    for (int i = 0; i < NDIG; i++)
      ones = ones + 4'(an_h[i]);
    legal = (ones == 4'd1);

    // cnt_nxt reaching CMAX implies the held sample matched this edge
    fire = armed && legal && (cnt_nxt == CMAX);
    {hit, nib} = dec7(seg_h);
    blank = (seg_h == 7'd0);
    seen_or = fire ? (seen | an_h) : seen;
    all_seen = &seen_or;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_h       <= '0;
      an_h        <= '0;
      cnt         <= '0;
      armed       <= 1'b1;
      seen        <= '0;
      value       <= '0;
      digit_valid <= '0;
      cap_stb     <= 1'b0;
      err_stb     <= 1'b0;
      frame_stb   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      cap_stb   <= fire && hit;
      err_stb   <= fire && !hit && !blank;
      frame_stb <= fire && all_seen;
      seen      <= (fire && all_seen) ? '0 : seen_or;
      if (!same) begin
        seg_h <= seg_s;
        an_h  <= an_s;
        armed <= 1'b1;
      end else if (fire) begin
        armed <= 1'b0;
      end
      for (int i = 0; i < NDIG; i++) begin
        if (fire && an_h[i]) begin
          digit_valid[i] <= hit;
          if (hit)
            value[4*i +: 4] <= nib;
        end
      end
    end
  end

endmodule
